// File: rtl/i2s_dac_tx.sv
// I2S (left-justified) DAC transmitter.
// A single-entry holding register buffers one {left,right} sample pair;
// a three-state sequencer generates the bit clock, channel select and
// MSB-first serial data, reloading a new frame at the end of each one.
module i2s_dac_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [15:0] LDATA,
    input  logic [15:0] RDATA,
    input  logic        SAMPLE_VALID,
    output logic        SAMPLE_READY,
    input  logic        UNDERRUN_CLR,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic        DATA_OVER,
    output logic        UNDERRUN,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a pair is transferred on any rising CLK edge where
    // SAMPLE_VALID and SAMPLE_READY are both 1. SAMPLE_READY depends only on
    // registered state, never on SAMPLE_VALID, and the captured pair reaches
    // the shifter no earlier than the following cycle.

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] div_cnt_q;
    logic [4:0]    bit_cnt_q;
    logic [31:0]   shifter_q;
    logic          bclk_q;
    logic          lrck_q;
    logic          dat_q;
    logic          data_over_q;

    logic [31:0]   hold_q, hold_d;
    logic          full_q, full_d;
    logic          ready_q;
    logic          underrun_q, underrun_d;

    logic          div_wrap;
    logic          bclk_fall;
    logic          frame_end;
    logic          frame_load;
    logic          accept;
    logic          underrun_set;
    logic [31:0]   load_word;
    logic [4:0]    bit_nxt;

    // Frame timing strobes and next-state of the holding register / flags.
    always_comb begin
        div_wrap     = (div_cnt_q == DIV_LAST);
        bclk_fall    = (state_q == ST_RUN) && div_wrap && bclk_q;
        frame_end    = bclk_fall && (bit_cnt_q == 5'd31);
        frame_load   = ((state_q == ST_SYNC) && ENABLE && full_q) ||
                       (frame_end && ENABLE);
        accept       = SAMPLE_VALID && ready_q;
        load_word    = full_q ? hold_q : 32'h0;
        underrun_set = frame_load && !full_q;
        bit_nxt      = bit_cnt_q + 5'd1;

        hold_d = accept ? {LDATA, RDATA} : hold_q;

        full_d = full_q;
        if (frame_load) full_d = 1'b0;
        if (accept)     full_d = 1'b1;

        // A set coinciding with a clear must leave the flag set.
        underrun_d = underrun_q;
        if (UNDERRUN_CLR) underrun_d = 1'b0;
        if (underrun_set) underrun_d = 1'b1;
    end

    // Holding register, full/ready flags and the sticky underrun flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hold_q     <= 32'h0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            full_q     <= full_d;
            ready_q    <= ~full_d;
            underrun_q <= underrun_d;
        end
    end

    // Sequencer: bit-clock divider, slot counter and registered serial pins.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= 5'd0;
            shifter_q   <= 32'h0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            dat_q       <= 1'b0;
            data_over_q <= 1'b0;
        end else begin
            data_over_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    bclk_q    <= 1'b0;
                    lrck_q    <= 1'b0;
                    dat_q     <= 1'b0;
                    div_cnt_q <= '0;
                    bit_cnt_q <= 5'd0;
                    if (ENABLE) state_q <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (!ENABLE) begin
                        state_q <= ST_IDLE;
                    end else if (full_q) begin
                        shifter_q <= load_word;
                        dat_q     <= load_word[31];
                        lrck_q    <= 1'b0;
                        bclk_q    <= 1'b0;
                        div_cnt_q <= '0;
                        bit_cnt_q <= 5'd0;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!div_wrap) begin
                        div_cnt_q <= div_cnt_q + DW'(1);
                    end else begin
                        div_cnt_q <= '0;
                        bclk_q    <= ~bclk_q;
                        if (bclk_q) begin
                            if (bit_cnt_q == 5'd31) begin
                                // End of slot 31: flag the frame and chain
                                // straight into the next one, or stop cleanly.
                                data_over_q <= 1'b1;
                                bit_cnt_q   <= 5'd0;
                                lrck_q      <= 1'b0;
                                if (ENABLE) begin
                                    shifter_q <= load_word;
                                    dat_q     <= load_word[31];
                                end else begin
                                    dat_q   <= 1'b0;
                                    state_q <= ST_IDLE;
                                end
                            end else begin
                                bit_cnt_q <= bit_nxt;
                                lrck_q    <= bit_nxt[4];
                                dat_q     <= shifter_q[5'd31 - bit_nxt];
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign SAMPLE_READY = ready_q;
    assign AUD_BCLK     = bclk_q;
    assign AUD_DACLRCK  = lrck_q;
    assign AUD_DACDAT   = dat_q;
    assign DATA_OVER    = data_over_q;
    assign UNDERRUN     = underrun_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx with CLK_DIV=2 (BCLK period 4 CLK,
// frame 128 CLK). Inputs are driven and outputs sampled on falling CLK.
module tb_i2s_dac_tx;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic [15:0] LDATA;
    logic [15:0] RDATA;
    logic        SAMPLE_VALID;
    logic        SAMPLE_READY;
    logic        UNDERRUN_CLR;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic        DATA_OVER;
    logic        UNDERRUN;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int fails   = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    i2s_dac_tx #(.CLK_DIV(2)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ENABLE       (ENABLE),
        .LDATA        (LDATA),
        .RDATA        (RDATA),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_READY (SAMPLE_READY),
        .UNDERRUN_CLR (UNDERRUN_CLR),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .DATA_OVER    (DATA_OVER),
        .UNDERRUN     (UNDERRUN),
        .dbg_state_o  (dbg_state)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Wait (bounded) for the sequencer to enter RUN; returns on slot 0, cycle 0.
    task automatic wait_run();
        int found;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge CLK);
            if (dbg_state === S_RUN) found = 1;
        end
        check("wait_run", found, 1);
    endtask

    // Capture one 128-cycle frame starting at slot 0 cycle 0, with optional
    // mid-frame stimulus (index -1 disables). Ends on cycle 0 of the next frame.
    task automatic run_frame(input int offer_at, input logic [31:0] pair,
                             input int clr_at, input int dis_at,
                             output logic [31:0] dat_w, output logic [31:0] lrck_w,
                             output int bad, output int do_in, output int rdy_hi,
                             output logic ur_pre, output logic ur_post);
        int slot;
        int ph;
        dat_w = 32'h0; lrck_w = 32'h0; bad = 0; do_in = 0; rdy_hi = 0;
        ur_pre = 1'b0; ur_post = 1'b0;
        for (int i = 0; i < 128; i++) begin
            slot = i / 4;
            ph   = i % 4;
            if (ph == 0) begin
                dat_w[31 - slot]  = AUD_DACDAT;
                lrck_w[31 - slot] = AUD_DACLRCK;
            end else begin
                if (AUD_DACDAT !== dat_w[31 - slot])   bad++;
                if (AUD_DACLRCK !== lrck_w[31 - slot]) bad++;
            end
            if (AUD_BCLK !== ((ph >= 2) ? 1'b1 : 1'b0)) bad++;
            if (i >= 1 && DATA_OVER === 1'b1) do_in++;
            if (offer_at >= 0 && i > offer_at && SAMPLE_READY === 1'b1) rdy_hi++;
            if (i == clr_at)     ur_pre  = UNDERRUN;
            if (i == clr_at + 1) ur_post = UNDERRUN;
            if (i == offer_at) begin
                {LDATA, RDATA} = pair;
                SAMPLE_VALID   = 1'b1;
            end
            if (i == offer_at + 1) SAMPLE_VALID = 1'b0;
            if (i == clr_at)       UNDERRUN_CLR = 1'b1;
            if (i == clr_at + 1)   UNDERRUN_CLR = 1'b0;
            if (i == dis_at)       ENABLE = 1'b0;
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [31:0] dw;
        logic [31:0] lw;
        int          bad;
        int          doi;
        int          rh;
        logic        up;
        logic        uq;

        RESET = 1'b0; ENABLE = 1'b0; LDATA = 16'h0; RDATA = 16'h0;
        SAMPLE_VALID = 1'b0; UNDERRUN_CLR = 1'b0;

        // Reset state
        step(); step();
        check("rst_ready",    SAMPLE_READY, 1);
        check("rst_bclk",     AUD_BCLK, 0);
        check("rst_lrck",     AUD_DACLRCK, 0);
        check("rst_dat",      AUD_DACDAT, 0);
        check("rst_dataover", DATA_OVER, 0);
        check("rst_underrun", UNDERRUN, 0);
        check("rst_state",    dbg_state, S_IDLE);
        RESET = 1'b1;
        step();

        // Offer first pair while idle
        LDATA = 16'hA5C3; RDATA = 16'h0F01; SAMPLE_VALID = 1'b1;
        step();
        SAMPLE_VALID = 1'b0;
        check("accept_ready_low", SAMPLE_READY, 0);
        check("idle_hold", dbg_state, S_IDLE);
        ENABLE = 1'b1;
        wait_run();
        check("f1_start_underrun", UNDERRUN, 0);

        // Frame 1: A5C30F01
        run_frame(-1, 32'h0, -1, -1, dw, lw, bad, doi, rh, up, uq);
        check("f1_data",      dw, 32'hA5C30F01);
        check("f1_lrck",      lw, 32'h0000FFFF);
        check("f1_bclk_stab", bad, 0);
        check("f1_do_inside", doi, 0);
        check("f1_end_do",    DATA_OVER, 1);
        check("f1_end_ur",    UNDERRUN, 1);
        check("f1_end_ready", SAMPLE_READY, 1);

        // Frame 2: underrun zeros; clear mid-frame
        run_frame(-1, 32'h0, 10, -1, dw, lw, bad, doi, rh, up, uq);
        check("f2_data",      dw, 32'h0);
        check("f2_bclk_stab", bad, 0);
        check("f2_ur_before", up, 1);
        check("f2_ur_after",  uq, 0);
        check("f2_end_do",    DATA_OVER, 1);
        check("f2_end_ur",    UNDERRUN, 1);

        // Frame 3: clear coincident with the underrun load at its end
        run_frame(-1, 32'h0, 127, -1, dw, lw, bad, doi, rh, up, uq);
        UNDERRUN_CLR = 1'b0;
        check("f3_ur_before",  up, 1);
        check("f3_do_inside",  doi, 0);
        check("f3_end_do",     DATA_OVER, 1);
        check("f3_coincident", UNDERRUN, 1);

        // Frame 4: clear flag and offer a second pair during the frame
        run_frame(3, 32'h1234_8001, 3, -1, dw, lw, bad, doi, rh, up, uq);
        check("f4_data",      dw, 32'h0);
        check("f4_ur_after",  uq, 0);
        check("f4_ready_low", rh, 0);
        check("f4_end_do",    DATA_OVER, 1);
        check("f4_end_ur",    UNDERRUN, 0);
        check("f4_end_ready", SAMPLE_READY, 1);

        // Frame 5: pair from frame 4; offer FFFF0000
        run_frame(2, 32'hFFFF_0000, -1, -1, dw, lw, bad, doi, rh, up, uq);
        check("f5_data",      dw, 32'h12348001);
        check("f5_lrck",      lw, 32'h0000FFFF);
        check("f5_bclk_stab", bad, 0);
        check("f5_do_inside", doi, 0);
        check("f5_ready_low", rh, 0);
        check("f5_end_do",    DATA_OVER, 1);
        check("f5_end_ur",    UNDERRUN, 0);

        // Frame 6: offer a pair to be retained, drop ENABLE in slot 5
        run_frame(4, 32'h7E81_C3A5, -1, 22, dw, lw, bad, doi, rh, up, uq);
        check("f6_data",      dw, 32'hFFFF0000);
        check("f6_bclk_stab", bad, 0);
        check("f6_ready_low", rh, 0);
        check("f6_end_do",    DATA_OVER, 1);
        check("f6_end_state", dbg_state, S_IDLE);
        check("f6_end_bclk",  AUD_BCLK, 0);
        check("f6_end_lrck",  AUD_DACLRCK, 0);
        check("f6_end_dat",   AUD_DACDAT, 0);
        check("f6_retained",  SAMPLE_READY, 0);
        check("f6_end_ur",    UNDERRUN, 0);
        step(); step();
        check("idle_do_low",  DATA_OVER, 0);
        check("idle_stays",   dbg_state, S_IDLE);
        check("idle_bclk",    AUD_BCLK, 0);

        // Frame 7 from the retained pair, reset in slot 20
        ENABLE = 1'b1;
        wait_run();
        check("f7_slot0_dat", AUD_DACDAT, 0);
        for (int i = 0; i < 82; i++) begin
            if (i == 4) check("f7_slot1_dat", AUD_DACDAT, 1);
            if (i == 40) begin
                LDATA = 16'h1111; RDATA = 16'h2222; SAMPLE_VALID = 1'b1;
            end
            if (i == 41) SAMPLE_VALID = 1'b0;
            step();
        end
        check("f7_pre_bclk",  AUD_BCLK, 1);
        check("f7_pre_lrck",  AUD_DACLRCK, 1);
        check("f7_pre_ready", SAMPLE_READY, 0);
        check("f7_pre_state", dbg_state, S_RUN);
        #2;
        RESET = 1'b0;
        #1;
        check("async_bclk",     AUD_BCLK, 0);
        check("async_lrck",     AUD_DACLRCK, 0);
        check("async_dat",      AUD_DACDAT, 0);
        check("async_dataover", DATA_OVER, 0);
        check("async_underrun", UNDERRUN, 0);
        check("async_ready",    SAMPLE_READY, 1);
        check("async_state",    dbg_state, S_IDLE);
        step();
        RESET = 1'b1;
        step();
        check("post_rst_ready", SAMPLE_READY, 1);
        check("post_rst_state", dbg_state, S_SYNC);
        step(); step(); step();
        check("post_rst_noload", dbg_state, S_SYNC);
        check("post_rst_bclk",   AUD_BCLK, 0);
        check("post_rst_ur",     UNDERRUN, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/i2s_dac_tx.md
I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: CLK cycles per AUD_BCLK half-period (legal values are 2 or more).
REQ-002 SHALL have port CLK  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port RESET  input  1  active-low, asynchronous reset.
REQ-004 SHALL have port ENABLE  input  1  level; 1 = run serial frames.
REQ-005 SHALL have port LDATA  input  16  left sample, two's complement.
REQ-006 SHALL have port RDATA  input  16  right sample, two's complement.
REQ-007 SHALL have port SAMPLE_VALID  input  1  LDATA/RDATA pair is offered.
REQ-008 SHALL have port SAMPLE_READY  output  1  the holding register is empty, so an offered pair can be accepted.
REQ-009 SHALL have port UNDERRUN_CLR  input  1  one-cycle pulse that clears UNDERRUN.
REQ-010 SHALL have port AUD_BCLK  output  1  codec bit clock.
REQ-011 SHALL have port AUD_DACLRCK  output  1  codec channel select; 0 = left, 1 = right.
REQ-012 SHALL have port AUD_DACDAT  output  1  codec serial data.
REQ-013 SHALL have port DATA_OVER  output  1  one-CLK pulse at the end of each frame.
REQ-014 SHALL have port UNDERRUN  output  1  sticky flag: a frame was loaded while no sample was held.

Function
REQ-015 SHALL keep one 32-bit holding register {LDATA,RDATA} and a full flag; SAMPLE_READY = not full, driven from a register.
REQ-016 SHALL capture {LDATA,RDATA} and set full on any cycle with SAMPLE_VALID=1 and SAMPLE_READY=1.
REQ-017 SHALL NOT pass an offered pair through to the shifter in the cycle it is accepted.
REQ-018 SHALL implement states IDLE, SYNC and RUN.
REQ-019 IDLE: AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0; go to SYNC when ENABLE=1.
REQ-020 SYNC: return to IDLE if ENABLE=0; otherwise, on the first cycle with full=1, load the shifter from holding, clear full and go to RUN.
REQ-021 RUN: div_cnt counts 0..CLK_DIV-1 and wraps; AUD_BCLK toggles each wrap. Slot 0 starts with AUD_BCLK low and div_cnt=0 on the cycle after the load.
REQ-022 A frame SHALL be 32 BCLK periods (slots 0..31), counted by a 5-bit bit_cnt that advances at each BCLK falling edge.
REQ-023 AUD_DACLRCK SHALL be 0 for slots 0..15 and 1 for slots 16..31.
REQ-024 AUD_DACDAT in slot k SHALL equal shifter bit 31-k (left-justified, MSB first, coincident with the LRCK edge); it changes only on BCLK falling edges.
REQ-025 At the falling edge that ends slot 31, DATA_OVER SHALL pulse high for exactly one CLK, and in the same cycle the next frame is loaded.
REQ-026 Frame load: if full=1, load the holding register and clear full. If full=0, load 32'h0 and set UNDERRUN.
REQ-027 UNDERRUN SHALL stay set until an UNDERRUN_CLR pulse; if a set and a clear occur in the same cycle, set wins.
REQ-028 ENABLE=0 in RUN: the current frame completes through slot 31 and DATA_OVER still pulses, then the block goes to IDLE without loading. Holding-register contents and full are retained.
REQ-029 Serial outputs SHALL be registered, with no combinational path from inputs to AUD_* pins.

Reset
REQ-030 While RESET=0: state=IDLE, SAMPLE_READY=1, full=0, AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, DATA_OVER=0, UNDERRUN=0, div_cnt=0, bit_cnt=0, shifter=0.
REQ-031 Reset asserted mid-frame SHALL force all REQ-030 values immediately, without waiting for CLK, and SHALL discard any held sample.

Verification
REQ-032 SHALL cover: CLK_DIV=2, ENABLE=1, one pair L=16'hA5C3, R=16'h0F01 -> AUD_DACDAT over slots 0..31 = A5C30F01 MSB first; AUD_BCLK period = 4 CLK; AUD_DACLRCK rises at slot 16; DATA_OVER pulses once after 128 CLK.
REQ-033 SHALL cover: no second pair supplied -> second frame serializes all zeros, UNDERRUN=1 from the load cycle and stays 1; an UNDERRUN_CLR pulse drops it to 0 the next cycle.
REQ-034 SHALL cover: a second pair accepted during frame 1 -> SAMPLE_READY=0 until the frame-2 load, then 1; no underrun; DATA_OVER spaced exactly 128 CLK apart.
REQ-035 SHALL cover: ENABLE dropped at slot 5 -> slots 6..31 complete, DATA_OVER pulses, then IDLE with AUD_BCLK=AUD_DACLRCK=AUD_DACDAT=0 and the held pair retained (SAMPLE_READY=0).
REQ-036 SHALL cover: RESET=0 at slot 20 -> all outputs take REQ-030 values asynchronously, and SAMPLE_READY=1 after release.
REQ-037 SHALL cover: UNDERRUN_CLR coincident with an underrun load -> UNDERRUN=1.
